dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the processor's dmem port (address_dmem/data/wren/q_dmem).
//  Owns the word-addressed data RAM for the decryption core.
//  Before the core runs, a host streams ciphertext into the RAM. After the core
//  writes DONE_ADDR, the block streams plaintext back to the host.
//  proc_hold gates the core's stall/reset in Wrapper while the host owns the RAM.
// PARAMETERS
//  ADDR_WIDTH  12          RAM word-address bits; DEPTH = 2**ADDR_WIDTH words
//  DUMP_BASE   0           first RAM word streamed out in DUMP
//  LEN_ADDR    32'hFFFF_FFF0  MMIO read: number of words loaded
//  CSUM_ADDR   32'hFFFF_FFF4  MMIO read: load checksum (optional feature)
//  DONE_ADDR   32'hFFFF_FFFC  MMIO write: data[ADDR_WIDTH:0] = words to dump
// PORTS
//  clock          in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  address_dmem   in   32  word address from the core
//  data           in   32  store data from the core
//  wren           in   1   store strobe from the core
//  q_dmem         out  32  read data; registered
//  proc_hold      out  1   1 = core must stall; host owns RAM
//  load_valid     in   1   host beat valid
//  load_ready     out  1   block accepts the host beat
//  load_data      in   32  host word
//  load_last      in   1   final host word
//  out_valid      out  1   dump beat valid
//  out_ready      in   1   host accepts the dump beat
//  out_data       out  32  dump word
//  out_last       out  1   final dump word
//  done           out  1   dump complete; high and sticky in HALT
// BEHAVIOUR
//  Reset: state=LOAD. load_ptr, count, dump_ptr, dump_len, csum and q_dmem are 0.
//   proc_hold=1, load_ready=1, out_valid=0, out_last=0, done=0.
//   RAM contents are not cleared. A reset during LOAD or DUMP abandons the
//   transfer, and the FSM restarts in LOAD.
//  FSM states: LOAD -> RUN -> DUMP -> HALT.
//  LOAD:
//   - Each cycle with load_valid&&load_ready writes RAM[load_ptr]=load_data,
//     then load_ptr++ and count++.
//   - load_last, or acceptance at load_ptr==DEPTH-1, moves to RUN on the next
//     cycle. A zero-length load is not possible; the host sends >=1 beat.
//  RUN:
//   - proc_hold=0 and load_ready=0.
//   - In-range access means address_dmem[31:ADDR_WIDTH]==0.
//   - In-range read: q_dmem <= RAM[addr] one rising edge after the address is
//     presented (1-cycle latency, valid within the core's half-cycle sample).
//   - In-range write: wren=1 writes RAM[addr]<=data. q_dmem that cycle returns
//     the old data (read-before-write).
//   - MMIO reads: LEN_ADDR -> count (zero-extended); CSUM_ADDR -> csum or 0.
//     Any other out-of-range read returns 0. Out-of-range writes are ignored,
//     except DONE_ADDR.
//   - Write to DONE_ADDR: dump_len <= data[ADDR_WIDTH:0], dump_ptr <= DUMP_BASE,
//     proc_hold=1 from the next cycle, state -> DUMP (or HALT if dump_len==0).
//  DUMP:
//   - The RAM port belongs to the dump engine; core wren is ignored.
//   - The RAM read is issued 1 cycle ahead. Output uses valid/ready with a
//     1-entry skid register.
//   - out_data and out_last stay stable while out_valid&&!out_ready.
//   - out_last=1 on beat dump_len-1. dump_ptr wraps modulo DEPTH.
//   - A handshake on the last beat moves to HALT.
//  HALT: proc_hold=1, done=1, out_valid=0 and load_ready=0 until reset.
//  Single RAM port, muxed by state. Load, core and dump never contend because
//   they own the port in disjoint states.
// CONFIGURATION
//  DMEM_LOAD_CHECKSUM_EN defined:
//   - csum <= csum ^ load_data on every accepted load beat.
//   - CSUM_ADDR reads return csum.
//  Undefined: no csum register; CSUM_ADDR reads return 0.
// STRUCTURE
//  dmem_pkg: state encoding (LOAD/RUN/DUMP/HALT) and the default
//   LEN/CSUM/DONE_ADDR constants.
//  Sub-module dmem_ram: single-port synchronous RAM (DEPTH x 32), registered
//   read, read-before-write.
//  Top level holds the FSM, pointers, MMIO decode and the dump skid register.
// TESTING
//  1 Reset, then load 4 beats 0x11,0x22,0x33,0x44 with load_last on the 4th.
//    Expect: proc_hold falls next cycle; a core read of addr 2 gives q_dmem=0x33
//    one edge later; LEN_ADDR reads 4.
//  2 RUN, wren=1 at addr 5 data 0xDEADBEEF.
//    Expect: same-cycle q_dmem=old value; next read gives 0xDEADBEEF.
//    A write to 0x0001_0000 leaves the RAM unchanged and reads 0.
//  3 Write DONE_ADDR data=3 with out_ready held at 0 for 5 cycles, then 1.
//    Expect: out_data=RAM[0] stable while stalled; beats RAM[0..2];
//    out_last on the 3rd; done=1 next cycle.
//  4 Write DONE_ADDR data=0.
//    Expect: no out_valid; HALT and done=1 the next cycle.
//  5 Assert reset mid-DUMP after 1 beat.
//    Expect: next cycle state=LOAD, proc_hold=1, load_ready=1, out_valid=0,
//    done=0.
//  6 With DMEM_LOAD_CHECKSUM_EN, load 0xF0,0x0F.
//    Expect: CSUM_ADDR reads 0xFF. Without the macro it reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared state encoding and default MMIO address map for the dmem responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [31:0] DEF_LEN_ADDR  = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_CSUM_ADDR = 32'hFFFF_FFF4;
  localparam logic [31:0] DEF_DONE_ADDR = 32'hFFFF_FFFC;
endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 synchronous RAM; registered read, read-before-write, no stall.
module dmem_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdat,
  output logic [31:0]           o_rdat
);
  logic [31:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
    o_rdat <= r_mem[i_addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data RAM owner: host load, core access (1-edge read latency), valid/ready dump with skid register.
// Optional load checksum at CSUM_ADDR when DMEM_LOAD_CHECKSUM_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DUMP_BASE  = 0,
  parameter logic [31:0] LEN_ADDR   = DEF_LEN_ADDR,
  parameter logic [31:0] CSUM_ADDR  = DEF_CSUM_ADDR,
  parameter logic [31:0] DONE_ADDR  = DEF_DONE_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        proc_hold,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        done
);
  localparam int            AW       = ADDR_WIDTH;
  localparam logic [AW-1:0] BASE_PTR = AW'(DUMP_BASE);
  localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_load_ptr, r_dump_ptr;
  logic [AW:0]   r_count, r_dump_len, r_issue_cnt;
  logic          r_rd_vld, r_rd_last;
  logic          r_out_vld, r_out_last, r_skid_vld, r_skid_last;
  logic [31:0]   r_out_dat, r_skid_dat;
  logic          r_rd_ram;
  logic [31:0]   r_mmio;
  logic [31:0]   w_csum, w_ram_q, w_mmio, w_ram_wdat;
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we, w_in_range, w_load_acc, w_done_wr, w_pop;
  logic          w_issue, w_issue_last;
  logic [1:0]    w_occ;

  assign w_in_range   = (address_dmem[31:AW] == '0);
  assign w_load_acc   = (r_state == ST_LOAD) && load_valid;
  assign w_done_wr    = (r_state == ST_RUN) && wren && (address_dmem == DONE_ADDR);
  assign w_pop        = r_out_vld && out_ready;
  // Reads in flight plus held beats never exceed the two output slots.
  assign w_occ        = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_rd_vld);
  assign w_issue_last = (r_issue_cnt == r_dump_len - CNT_ONE);
  assign w_issue      = (r_state == ST_DUMP) && (r_issue_cnt != r_dump_len)
                     && ((w_occ - 2'(w_pop)) <= 2'd1);

`ifdef DMEM_LOAD_CHECKSUM_EN
  logic [31:0] r_csum;
  always_ff @(posedge clock) begin
    if (reset)           r_csum <= '0;
    else if (w_load_acc) r_csum <= r_csum ^ load_data;
  end
  assign w_csum = r_csum;
`else
  assign w_csum = '0;
`endif

  always_comb begin
    w_mmio = '0;
    if (address_dmem == LEN_ADDR)       w_mmio = 32'(r_count);
    else if (address_dmem == CSUM_ADDR) w_mmio = w_csum;
  end

  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = r_dump_ptr;
    w_ram_wdat = data;
    case (r_state)
      ST_LOAD: begin
        w_ram_we   = w_load_acc;
        w_ram_addr = r_load_ptr;
        w_ram_wdat = load_data;
      end
      ST_RUN: begin
        w_ram_we   = wren && w_in_range;
        w_ram_addr = address_dmem[AW-1:0];
      end
      default: ;
    endcase
  end

  dmem_ram #(.ADDR_WIDTH(AW)) u_ram (
    .i_clk  (clock),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdat (w_ram_wdat),
    .o_rdat (w_ram_q)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    proc_hold   = 1'b1;
    load_ready  = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (w_load_acc && (load_last || r_load_ptr == LAST_PTR)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        proc_hold = 1'b0;
        if (w_done_wr) w_state_nxt = (data[AW:0] == '0) ? ST_HALT : ST_DUMP;
      end
      ST_DUMP: if (w_pop && r_out_last) w_state_nxt = ST_HALT;
      default: begin
        done        = 1'b1;
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_ptr  <= '0;
      r_count     <= '0;
      r_dump_ptr  <= '0;
      r_dump_len  <= '0;
      r_issue_cnt <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_dat   <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_dat  <= '0;
      r_rd_ram    <= 1'b0;
      r_mmio      <= '0;
    end else begin
      if (w_load_acc) begin
        r_load_ptr <= r_load_ptr + PTR_ONE;
        r_count    <= r_count + CNT_ONE;
      end
      if (w_done_wr) begin
        r_dump_len  <= data[AW:0];
        r_dump_ptr  <= BASE_PTR;
        r_issue_cnt <= '0;
      end
      if (w_issue) begin
        r_dump_ptr  <= r_dump_ptr + PTR_ONE;
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && w_issue_last;
      // Output slot refills from the skid first so beat order is kept.
      if (w_pop || !r_out_vld) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_dat   <= r_skid_dat;
          r_out_last  <= r_skid_last;
          r_skid_vld  <= r_rd_vld;
          r_skid_dat  <= w_ram_q;
          r_skid_last <= r_rd_last;
        end else begin
          r_out_vld  <= r_rd_vld;
          r_out_dat  <= w_ram_q;
          r_out_last <= r_rd_last;
        end
      end else if (r_rd_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_dat  <= w_ram_q;
        r_skid_last <= r_rd_last;
      end
      r_rd_ram <= (r_state == ST_RUN) && w_in_range;
      r_mmio   <= ((r_state == ST_RUN) && !w_in_range) ? w_mmio : '0;
    end
  end

  assign q_dmem    = r_rd_ram ? w_ram_q : r_mmio;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_last  = r_out_last;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: core-access vector table, directed dump/reset corners,
// randomized load/access/dump traffic against a word-level RAM model.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int          AW     = 12;
  localparam int          DEPTH  = 1 << AW;
  localparam logic [31:0] LEN_A  = 32'hFFFF_FFF0;
  localparam logic [31:0] CSUM_A = 32'hFFFF_FFF4;
  localparam logic [31:0] DONE_A = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0, data = '0, load_data = '0;
  logic        wren = 1'b0, load_valid = 1'b0, load_last = 1'b0, out_ready = 1'b0;
  logic [31:0] q_dmem, out_data;
  logic        proc_hold, load_ready, out_valid, out_last, done;

  always #5 clock = ~clock;

  dmem_responder dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .proc_hold(proc_hold), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_count = 0;
  logic [31:0] m_csum  = '0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdat;
    bit          chk;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] csum_exp();
`ifdef DMEM_LOAD_CHECKSUM_EN
    return m_csum;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit valid);
    valid = 1'b1;
    if (a[31:AW] == '0) begin
      valid = m_known[a[AW-1:0]];
      return m_mem[a[AW-1:0]];
    end
    if (a == LEN_A)  return 32'(m_count);
    if (a == CSUM_A) return csum_exp();
    return 32'h0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; wren = 1'b0;
    out_ready = 1'b0; address_dmem = '0; data = '0;
    step(); step();
    reset = 1'b0;
    m_count = 0; m_csum = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_proc_hold"},  32'(proc_hold),  32'h1);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'h1);
    chk({tag, "_out_valid"},  32'(out_valid),  32'h0);
    chk({tag, "_out_last"},   32'(out_last),   32'h0);
    chk({tag, "_done"},       32'(done),       32'h0);
    chk({tag, "_q_dmem"},     q_dmem,          32'h0);
  endtask

  task automatic load_words(input logic [31:0] words[$], input bit use_last, input bit gaps);
    foreach (words[i]) begin
      repeat (gaps ? $urandom_range(0, 2) : 0) begin
        load_valid = 1'b0;
        step();
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == words.size() - 1);
      if (load_ready !== 1'b1) begin
        chk("load_ready_during_load", 32'(load_ready), 32'h1);
        break;
      end
      step();
      m_mem[m_count % DEPTH]   = words[i];
      m_known[m_count % DEPTH] = 1'b1;
      m_count++;
      m_csum ^= words[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic core(input logic [31:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] q);
    address_dmem = a; wren = w; data = d;
    step();
    q = q_dmem;
    wren = 1'b0;
    if (w && a[31:AW] == '0) begin
      m_mem[a[AW-1:0]]   = d;
      m_known[a[AW-1:0]] = 1'b1;
    end
  endtask

  task automatic run_dump(input int len, input int stall, input bit rnd);
    int          beat   = 0;
    int          cyc    = 0;
    int          budget = stall + len * 8 + 50;
    logic        pv     = 1'b0;
    logic [31:0] pd     = '0;
    logic        pl     = 1'b0;
    address_dmem = DONE_A; data = 32'(len); wren = 1'b1; out_ready = 1'b0;
    step();
    wren = 1'b0; address_dmem = '0;
    chk("dump_proc_hold", 32'(proc_hold), 32'h1);
    while (beat < len && cyc < budget) begin
      out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (pv) begin
        chk("stall_hold_valid", 32'(out_valid), 32'h1);
        chk("stall_hold_data",  out_data,       pd);
        chk("stall_hold_last",  32'(out_last),  32'(pl));
      end
      if (stall > 0 && cyc == stall) begin
        chk("stalled_first_valid", 32'(out_valid), 32'h1);
        chk("stalled_first_data",  out_data,       m_mem[0]);
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (out_valid && out_ready) begin
        chk($sformatf("dump_data_%0d", beat), out_data, m_mem[beat % DEPTH]);
        chk($sformatf("dump_last_%0d", beat), 32'(out_last), 32'(beat == len - 1));
        chk("dump_done_early", 32'(done), 32'h0);
        beat++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_beat_count", 32'(beat), 32'(len));
    chk("halt_done",      32'(done),      32'h1);
    chk("halt_out_valid", 32'(out_valid), 32'h0);
    chk("halt_proc_hold", 32'(proc_hold), 32'h1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, e, a, d;
    logic [31:0] wq[$];
    bit          v, hs;
    logic        w;

    // Reset values and basic load of four words.
    do_reset();
    check_reset_state("rst");
    wq = '{32'h11, 32'h22, 32'h33, 32'h44};
    load_words(wq, 1'b1, 1'b0);
    chk("run_proc_hold",  32'(proc_hold),  32'h0);
    chk("run_load_ready", 32'(load_ready), 32'h0);

    vt.delete();
    vt.push_back('{32'd2,        1'b0, 32'h0,        1'b1, 32'h33});
    vt.push_back('{LEN_A,        1'b0, 32'h0,        1'b1, 32'h4});
    vt.push_back('{32'd0,        1'b0, 32'h0,        1'b1, 32'h11});
    vt.push_back('{32'd3,        1'b0, 32'h0,        1'b1, 32'h44});
    vt.push_back('{32'd5,        1'b1, 32'h55,       1'b0, 32'h0});
    vt.push_back('{32'd5,        1'b1, 32'hDEADBEEF, 1'b1, 32'h55});
    vt.push_back('{32'd5,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF});
    vt.push_back('{32'h0001_0000, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0});
    vt.push_back('{32'h0001_0000, 1'b0, 32'h0,        1'b1, 32'h0});
    vt.push_back('{32'd0,        1'b0, 32'h0,        1'b1, 32'h11});
    vt.push_back('{CSUM_A,       1'b0, 32'h0,        1'b1, csum_exp()});
    vt.push_back('{LEN_A,        1'b1, 32'h123,      1'b1, 32'h4});
    vt.push_back('{LEN_A,        1'b0, 32'h0,        1'b1, 32'h4});
    vt.push_back('{32'hFFFF_FFF8, 1'b0, 32'h0,        1'b1, 32'h0});
    vt.push_back('{32'd1,        1'b0, 32'h0,        1'b1, 32'h22});
    foreach (vt[i]) begin
      core(vt[i].addr, vt[i].wr, vt[i].wdat, q);
      if (vt[i].chk) chk($sformatf("vec%0d", i), q, vt[i].exp);
    end

    // Randomized core traffic in RUN, addresses 5..15 plus MMIO and out-of-range.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        7:       a = LEN_A;
        8:       a = CSUM_A;
        9:       a = ($urandom_range(1, 255) << AW) | $urandom_range(0, DEPTH - 1);
        default: a = 32'($urandom_range(5, 15));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      e = exp_read(a, v);
      core(a, w, d, q);
      if (v) chk($sformatf("rnd_core_%0d", i), q, e);
    end

    // Dump of three words with five stalled cycles first.
    run_dump(3, 5, 1'b0);

    // Zero-length dump goes straight to HALT.
    do_reset();
    wq = '{32'hA1, 32'hA2};
    load_words(wq, 1'b1, 1'b0);
    address_dmem = DONE_A; data = 32'h0; wren = 1'b1;
    step();
    wren = 1'b0;
    chk("zlen_done",      32'(done),      32'h1);
    chk("zlen_proc_hold", 32'(proc_hold), 32'h1);
    chk("zlen_out_valid", 32'(out_valid), 32'h0);
    repeat (3) begin
      step();
      chk("zlen_idle_valid", 32'(out_valid), 32'h0);
      chk("zlen_idle_done",  32'(done),      32'h1);
    end

    // Reset after the first dump beat abandons the dump.
    do_reset();
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    load_words(wq, 1'b1, 1'b1);
    address_dmem = DONE_A; data = 32'd6; wren = 1'b1;
    step();
    wren = 1'b0; out_ready = 1'b1; hs = 1'b0;
    for (int c = 0; c < 20 && !hs; c++) begin
      hs = out_valid;
      step();
    end
    chk("mid_dump_beat_seen", 32'(hs), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0;
    m_count = 0; m_csum = '0;
    check_reset_state("mid_dump_rst");

    // Checksum of two loaded words.
    wq = '{32'hF0, 32'h0F};
    load_words(wq, 1'b1, 1'b0);
    core(CSUM_A, 1'b0, 32'h0, q);
`ifdef DMEM_LOAD_CHECKSUM_EN
    chk("csum_f0_0f", q, 32'hFF);
`else
    chk("csum_f0_0f", q, 32'h0);
`endif
    core(LEN_A, 1'b0, 32'h0, q);
    chk("len_two", q, 32'h2);

    // Random load with gaps, core edits, random-backpressure dump.
    do_reset();
    wq.delete();
    for (int i = 0; i < 20; i++) wq.push_back($urandom);
    load_words(wq, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) core(32'($urandom_range(0, 19)), 1'b1, $urandom, q);
    core(CSUM_A, 1'b0, 32'h0, q);
    chk("rnd_csum", q, csum_exp());
    run_dump(20, 0, 1'b1);

    // Full-depth load without load_last, then a dump that wraps past DEPTH.
    do_reset();
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'(i * 3 + 1));
    load_words(wq, 1'b0, 1'b0);
    chk("full_proc_hold",  32'(proc_hold),  32'h0);
    chk("full_load_ready", 32'(load_ready), 32'h0);
    core(LEN_A, 1'b0, 32'h0, q);
    chk("full_len", q, 32'h1000);
    core(32'd0, 1'b1, 32'h5A5A_0000, q);
    chk("full_rbw_word0", q, 32'h1);
    run_dump(DEPTH + 1, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
